led_palette_fader: RTL and testbench
====================================

Name: led_palette_fader

Overview:
- Upstream stage of the LED PWM driver.
- Holds a target palette for N color LEDs (8-bit R/G/B each) and B basic LEDs (8-bit luminance each), loaded one LED at a time over a valid/ready command port.
- Ramps a "current" palette toward the targets by a fixed step on a millisecond tick.
- Drives the current palette as the packed 8-bit-per-LED vectors that the PWM driver consumes.

Parameters:
- parm_color_led_count, 4, number of RGB LEDs (N).
- parm_basic_led_count, 4, number of single-filament LEDs (B).
- parm_FCLK, 40_000_000, clock frequency in Hz.
- parm_fade_step_milliseconds, 1, fade tick period in ms.
- parm_fade_step_size, 16, unsigned 8-bit increment applied per tick per channel (1..255).

Ports:
- i_clk  in  1  system clock.
- i_arst_n  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when valid&&ready.
- i_cmd_is_basic  in  1  0=color LED command, 1=basic LED command.
- i_cmd_index  in  8  LED index within the selected group.
- i_cmd_fade  in  1  1=ramp to target, 0=jump immediately.
- i_cmd_red, i_cmd_green, i_cmd_blue  in  8 each  color targets; ignored for basic commands.
- i_cmd_lumin  in  8  basic target; ignored for color commands.
- o_color_led_red_value, o_color_led_green_value, o_color_led_blue_value  out  8*N each  current values; LED k occupies bits [8k+7:8k].
- o_basic_led_lumin_value  out  8*B  current luminance, same packing.
- o_busy  out  1  fade in progress.

Behaviour:
- Reset (async assert on i_arst_n=0, synchronous release):
  - All targets and current values = 0; outputs = 0.
  - o_cmd_ready=0, o_busy=0, state=ST_IDLE, tick counter=0, pending tick=0.
  - o_cmd_ready rises on the first clock edge after release.
- Tick: free-running counter of c_tick_period = parm_FCLK/1000*parm_fade_step_milliseconds cycles; one-cycle tick at terminal count, then wraps to 0.
- Channel numbering (C = 3N+B): j=0..N-1 red, N..2N-1 green, 2N..3N-1 blue, 3N..C-1 lumin.
- FSM:
  - ST_IDLE: o_cmd_ready=1. On tick or pending tick → ST_SWEEP, j=0, clear pending.
  - ST_SWEEP: o_cmd_ready=0. Each cycle channel j is updated, then j+1. After j=C-1 → ST_IDLE, or → ST_SWEEP with j=0 if pending is set.
  - A tick arriving during ST_SWEEP sets pending. Multiple ticks collapse into one.
- o_cmd_ready is registered (equals next-state==ST_IDLE). Commands are accepted only in ST_IDLE.
- Step rule, unsigned 8-bit, never wraps:
  - if |target-current| <= step: current=target.
  - else: current ±= step.
- Command accept:
  - Writes the target(s) of the addressed LED.
  - With i_cmd_fade=0, also writes current; the output changes on the cycle after accept.
  - With i_cmd_fade=1, the output first changes one cycle after that channel's slot in the next sweep.
  - i_cmd_index >= group count: command is accepted and discarded, no state change.
- o_busy:
  - Set on accept of a fade command whose target differs from current.
  - Cleared at the end of a sweep after which every current equals its target.
  - An immediate command never sets o_busy.
- Reset mid-sweep: everything returns to reset values immediately; the partially updated palette is lost.
- Width rule: product/sum widths kept at 9 bits internally for compare; results saturate to target, never exceed 8 bits.
- Elaboration check: c_tick_period must be >= C+2; error otherwise.

Decomposition:
- Package led_palette_pkg holds:
  - State enum (ST_IDLE, ST_SWEEP).
  - Function fn_step_toward(current, target, step) returning 8 bits.
  - Channel-count helper constants.
- One sub-module, led_fade_tick_gen: parameterized period counter producing the one-cycle tick, same clock/reset.

Test Plan:
- Use parm_FCLK=1_000_000 (tick every 1000 cycles), N=4, B=4, step 16 for all scenarios.
- Reset release → all outputs 0x00, o_busy=0; o_cmd_ready=0 during reset and 1 one cycle after release.
- Immediate color cmd idx 2, R/G/B=0x80/0x40/0xFF → o_color_led_red_value[23:16]=0x80, green=0x40, blue=0xFF one cycle after accept; other LEDs unchanged; o_busy stays 0.
- Fade basic cmd idx 1 to 0xFF from 0:
  - Lumin[15:8] steps 0x10, 0x20, ... 0xF0.
  - Reaches 0xFF at tick 16.
  - o_busy drops at the end of that sweep.
- Fade down: red LED 0 at 0x25, target 0x00 → 0x15, 0x05, 0x00 on three successive ticks; never wraps to 0xF5.
- Out-of-range cmd: i_cmd_index=7 for color → accepted (one-cycle handshake), all outputs and o_busy unchanged.
- Reset handling:
  - Hold valid during a sweep → o_cmd_ready=0 for exactly C=16 cycles, then accept.
  - Assert i_arst_n=0 mid-sweep → outputs 0x00 in the same cycle, no further updates until the next tick.

Source files
------------

// File: rtl/led_palette_pkg.sv
// Shared types and helpers for the LED palette fader: FSM states, channel counts and the saturating step rule.
package led_palette_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  localparam int c_chan_per_color = 3;

  function automatic int fn_channel_count(input int n_color, input int n_basic);
    return c_chan_per_color * n_color + n_basic;
  endfunction

  function automatic int fn_tick_period(input int unsigned fclk, input int unsigned step_ms);
    return int'(fclk / 1000 * step_ms);
  endfunction

  // The 9-bit distance makes the "close enough" test exact, so the result lands on target instead of wrapping.
  function automatic logic [7:0] fn_step_toward(input logic [7:0] current,
                                                input logic [7:0] target,
                                                input logic [7:0] step);
    logic [8:0] diff;
    logic [7:0] res;
    if (target >= current) begin
      diff = {1'b0, target} - {1'b0, current};
      res  = (diff <= {1'b0, step}) ? target : current + step;
    end else begin
      diff = {1'b0, current} - {1'b0, target};
      res  = (diff <= {1'b0, step}) ? target : current - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_fade_tick_gen.sv
// Free-running period counter; o_tick is high for one cycle at the terminal count, then the count wraps to 0.
module led_fade_tick_gen #(
  parameter int unsigned parm_period = 40000
) (
  input  logic i_clk,
  input  logic i_arst_n,
  output logic o_tick
);

  localparam int unsigned c_cnt_w = (parm_period > 1) ? $clog2(parm_period) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(parm_period - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == c_last) ? '0 : cnt_q + c_cnt_w'(1);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == c_last);

endmodule

// File: rtl/led_palette_fader.sv
// Holds target/current LED palettes, loads targets over valid/ready, and sweeps every channel toward target once per tick.
// Commands are accepted only while idle; a sweep takes one cycle per channel and holds o_cmd_ready low meanwhile.
module led_palette_fader
  import led_palette_pkg::*;
#(
  parameter int          parm_color_led_count        = 4,
  parameter int          parm_basic_led_count        = 4,
  parameter int unsigned parm_FCLK                   = 40_000_000,
  parameter int unsigned parm_fade_step_milliseconds = 1,
  parameter int          parm_fade_step_size         = 16
) (
  input  logic                              i_clk,
  input  logic                              i_arst_n,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic                              i_cmd_is_basic,
  input  logic [7:0]                        i_cmd_index,
  input  logic                              i_cmd_fade,
  input  logic [7:0]                        i_cmd_red,
  input  logic [7:0]                        i_cmd_green,
  input  logic [7:0]                        i_cmd_blue,
  input  logic [7:0]                        i_cmd_lumin,
  output logic [8*parm_color_led_count-1:0] o_color_led_red_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_green_value,
  output logic [8*parm_color_led_count-1:0] o_color_led_blue_value,
  output logic [8*parm_basic_led_count-1:0] o_basic_led_lumin_value,
  output logic                              o_busy
);

  localparam int c_n           = parm_color_led_count;
  localparam int c_b           = parm_basic_led_count;
  localparam int c_chan        = fn_channel_count(c_n, c_b);
  localparam int c_tick_period = fn_tick_period(parm_FCLK, parm_fade_step_milliseconds);
  localparam int c_idx_w       = (c_chan > 1) ? $clog2(c_chan) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_chan - 1);
  localparam logic [7:0]         c_step     = 8'(parm_fade_step_size);

  if (c_tick_period < c_chan + 2) begin : g_period_check
    $error("led_palette_fader: tick period %0d shorter than channel count + 2 (%0d)", c_tick_period, c_chan + 2);
  end
  if (parm_fade_step_size < 1 || parm_fade_step_size > 255) begin : g_step_check
    $error("led_palette_fader: fade step %0d outside 1..255", parm_fade_step_size);
  end

  logic tick;

  led_fade_tick_gen #(
    .parm_period(c_tick_period)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .o_tick  (tick)
  );

  state_e             state_q, state_d;
  logic [c_idx_w-1:0] idx_q, idx_d;
  logic               pending_q, pending_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               settled_q, settled_d;
  logic [7:0]         cur_q [c_chan];
  logic [7:0]         cur_d [c_chan];
  logic [7:0]         tgt_q [c_chan];
  logic [7:0]         tgt_d [c_chan];
  logic               cmd_fire;

  assign cmd_fire = i_cmd_valid && cmd_ready_q && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    settled_d = settled_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          // Out-of-range indices match no slot, so they are consumed without effect.
          for (int k = 0; k < c_n; k++) begin
            if (!i_cmd_is_basic && i_cmd_index == 8'(k)) begin
              tgt_d[k]         = i_cmd_red;
              tgt_d[c_n+k]     = i_cmd_green;
              tgt_d[2*c_n+k]   = i_cmd_blue;
              if (i_cmd_fade) begin
                if (i_cmd_red != cur_q[k] || i_cmd_green != cur_q[c_n+k] ||
                    i_cmd_blue != cur_q[2*c_n+k]) begin
                  busy_d = 1'b1;
                end
              end else begin
                cur_d[k]       = i_cmd_red;
                cur_d[c_n+k]   = i_cmd_green;
                cur_d[2*c_n+k] = i_cmd_blue;
              end
            end
          end
          for (int k = 0; k < c_b; k++) begin
            if (i_cmd_is_basic && i_cmd_index == 8'(k)) begin
              tgt_d[3*c_n+k] = i_cmd_lumin;
              if (i_cmd_fade) begin
                if (i_cmd_lumin != cur_q[3*c_n+k]) busy_d = 1'b1;
              end else begin
                cur_d[3*c_n+k] = i_cmd_lumin;
              end
            end
          end
        end
        if (tick || pending_q) begin
          state_d   = ST_SWEEP;
          idx_d     = '0;
          pending_d = 1'b0;
          settled_d = 1'b1;
        end
      end

      ST_SWEEP: begin
        if (tick) pending_d = 1'b1;
        for (int c = 0; c < c_chan; c++) begin
          if (idx_q == c_idx_w'(c)) begin
            cur_d[c] = fn_step_toward(cur_q[c], tgt_q[c], c_step);
            if (cur_d[c] != tgt_q[c]) settled_d = 1'b0;
          end
        end
        if (idx_q == c_last_idx) begin
          if (settled_d) busy_d = 1'b0;
          if (tick || pending_q) begin
            idx_d     = '0;
            pending_d = 1'b0;
            settled_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + c_idx_w'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      settled_q   <= 1'b0;
      for (int c = 0; c < c_chan; c++) begin
        cur_q[c] <= '0;
        tgt_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      settled_q   <= settled_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
    end
  end

  for (genvar k = 0; k < c_n; k++) begin : g_color_out
    assign o_color_led_red_value[8*k +: 8]   = cur_q[k];
    assign o_color_led_green_value[8*k +: 8] = cur_q[c_n+k];
    assign o_color_led_blue_value[8*k +: 8]  = cur_q[2*c_n+k];
  end
  for (genvar k = 0; k < c_b; k++) begin : g_basic_out
    assign o_basic_led_lumin_value[8*k +: 8] = cur_q[3*c_n+k];
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_led_palette_fader.sv
// Self-checking bench for led_palette_fader: a behavioural palette model feeds a scoreboard of expected snapshots.
module tb_led_palette_fader;

  localparam int          N    = 4;
  localparam int          B    = 4;
  localparam int          C    = 3 * N + B;
  localparam int          STEP = 16;
  localparam int unsigned FCLK = 1_000_000;

  logic           clk = 1'b0;
  logic           arst_n = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_is_basic = 1'b0;
  logic [7:0]     cmd_index = '0;
  logic           cmd_fade = 1'b0;
  logic [7:0]     cmd_red = '0, cmd_green = '0, cmd_blue = '0, cmd_lumin = '0;
  logic [8*N-1:0] red_v, grn_v, blu_v;
  logic [8*B-1:0] lum_v;
  logic           busy;

  always #5 clk = ~clk;

  led_palette_fader #(
    .parm_color_led_count       (N),
    .parm_basic_led_count       (B),
    .parm_FCLK                  (FCLK),
    .parm_fade_step_milliseconds(1),
    .parm_fade_step_size        (STEP)
  ) dut (
    .i_clk                  (clk),
    .i_arst_n               (arst_n),
    .i_cmd_valid            (cmd_valid),
    .o_cmd_ready            (cmd_ready),
    .i_cmd_is_basic         (cmd_is_basic),
    .i_cmd_index            (cmd_index),
    .i_cmd_fade             (cmd_fade),
    .i_cmd_red              (cmd_red),
    .i_cmd_green            (cmd_green),
    .i_cmd_blue             (cmd_blue),
    .i_cmd_lumin            (cmd_lumin),
    .o_color_led_red_value  (red_v),
    .o_color_led_green_value(grn_v),
    .o_color_led_blue_value (blu_v),
    .o_basic_led_lumin_value(lum_v),
    .o_busy                 (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int   mcur [C];
  int   mtgt [C];
  logic mbusy;

  typedef struct packed {
    logic [8*C-1:0] pal;
    logic           busy;
  } snap_t;
  snap_t sb_q [$];

  function automatic logic [8*C-1:0] dut_pal();
    return {lum_v, blu_v, grn_v, red_v};
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < C; c++) begin
      mcur[c] = 0;
      mtgt[c] = 0;
    end
    mbusy = 1'b0;
    sb_q.delete();
  endfunction

  function automatic void push_expected();
    snap_t s;
    for (int c = 0; c < C; c++) s.pal[8*c +: 8] = 8'(mcur[c]);
    s.busy = mbusy;
    sb_q.push_back(s);
  endfunction

  function automatic void model_sweep();
    bit all_eq = 1'b1;
    for (int c = 0; c < C; c++) begin
      int d = mtgt[c] - mcur[c];
      if (d > STEP)       mcur[c] = mcur[c] + STEP;
      else if (d < -STEP) mcur[c] = mcur[c] - STEP;
      else                mcur[c] = mtgt[c];
      if (mcur[c] != mtgt[c]) all_eq = 1'b0;
    end
    if (all_eq) mbusy = 1'b0;
  endfunction

  function automatic void model_cmd(input bit basic, input int idx, input bit fade,
                                    input int rr, input int gg, input int bb, input int ll);
    int ch [3];
    int val [3];
    int n;
    if (basic) begin
      if (idx >= B) return;
      ch[0] = 3 * N + idx; val[0] = ll; n = 1;
    end else begin
      if (idx >= N) return;
      ch[0] = idx;       val[0] = rr;
      ch[1] = N + idx;   val[1] = gg;
      ch[2] = 2*N + idx; val[2] = bb;
      n = 3;
    end
    for (int i = 0; i < n; i++) begin
      mtgt[ch[i]] = val[i];
      if (!fade) mcur[ch[i]] = val[i];
      else if (val[i] != mcur[ch[i]]) mbusy = 1'b1;
    end
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit basic, input logic [7:0] idx, input bit fade,
                          input logic [7:0] rr, input logic [7:0] gg,
                          input logic [7:0] bb, input logic [7:0] ll);
    int waited = 0;
    cmd_is_basic = basic;
    cmd_index    = idx;
    cmd_fade     = fade;
    cmd_red      = rr;
    cmd_green    = gg;
    cmd_blue     = bb;
    cmd_lumin    = ll;
    cmd_valid    = 1'b1;
    while (!cmd_ready && waited < 2000) begin
      step_clk();
      waited++;
    end
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL cmd_handshake: ready=%0b after %0d cycles, expected 1", cmd_ready, waited);
    end
    step_clk();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_sweep();
    int w = 0;
    while (cmd_ready && w < 1100) begin
      step_clk();
      w++;
    end
    while (!cmd_ready && w < 2200) begin
      step_clk();
      w++;
    end
    n_checks++;
    if (w >= 1100 && !(w < 2200 && cmd_ready)) begin
      n_fail++;
      $display("FAIL sweep_timeout: ready=%0b after %0d cycles, expected a completed sweep", cmd_ready, w);
    end
  endtask

  task automatic test_reset();
    #2 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
    n_checks++;
    if (dut_pal() !== '0) begin n_fail++; $display("FAIL reset_palette: got %h expected 0", dut_pal()); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    arst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b expected 0", cmd_ready); end
    step_clk();
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b expected 1", cmd_ready); end
    model_reset();
  endtask

  task automatic test_immediate();
    snap_t e;
    send_cmd(1'b0, 8'd2, 1'b0, 8'h80, 8'h40, 8'hFF, 8'h00);
    model_cmd(1'b0, 2, 1'b0, 'h80, 'h40, 'hFF, 0);
    push_expected();
    e = sb_q.pop_front();
    n_checks++;
    if (dut_pal() !== e.pal) begin n_fail++; $display("FAIL immediate_palette: got %h expected %h", dut_pal(), e.pal); end
    n_checks++;
    if (busy !== e.busy) begin n_fail++; $display("FAIL immediate_busy: got %b expected %b", busy, e.busy); end
    n_checks++;
    if (red_v[23:16] !== 8'h80 || grn_v[23:16] !== 8'h40 || blu_v[23:16] !== 8'hFF) begin
      n_fail++;
      $display("FAIL immediate_led2: got %h/%h/%h expected 80/40/ff", red_v[23:16], grn_v[23:16], blu_v[23:16]);
    end
  endtask

  task automatic test_fade_up();
    snap_t      e;
    logic [7:0] lit;
    send_cmd(1'b1, 8'd1, 1'b1, 8'h00, 8'h00, 8'h00, 8'hFF);
    model_cmd(1'b1, 1, 1'b1, 0, 0, 0, 'hFF);
    push_expected();
    for (int k = 1; k <= 16; k++) begin
      model_sweep();
      push_expected();
    end
    e = sb_q.pop_front();
    n_checks++;
    if (dut_pal() !== e.pal || busy !== e.busy) begin
      n_fail++;
      $display("FAIL fade_up_accept: got %h busy %b expected %h busy %b", dut_pal(), busy, e.pal, e.busy);
    end
    for (int k = 1; k <= 16; k++) begin
      wait_sweep();
      e = sb_q.pop_front();
      n_checks++;
      if (dut_pal() !== e.pal || busy !== e.busy) begin
        n_fail++;
        $display("FAIL fade_up_tick%0d: got %h busy %b expected %h busy %b", k, dut_pal(), busy, e.pal, e.busy);
      end
      lit = (k < 16) ? 8'(16 * k) : 8'hFF;
      n_checks++;
      if (lum_v[15:8] !== lit) begin
        n_fail++;
        $display("FAIL fade_up_lumin%0d: got %h expected %h", k, lum_v[15:8], lit);
      end
    end
  endtask

  task automatic test_fade_down();
    snap_t      e;
    logic [7:0] lit [3] = '{8'h15, 8'h05, 8'h00};
    send_cmd(1'b0, 8'd0, 1'b0, 8'h25, 8'h00, 8'h00, 8'h00);
    model_cmd(1'b0, 0, 1'b0, 'h25, 0, 0, 0);
    push_expected();
    e = sb_q.pop_front();
    n_checks++;
    if (dut_pal() !== e.pal) begin n_fail++; $display("FAIL fade_down_preset: got %h expected %h", dut_pal(), e.pal); end
    send_cmd(1'b0, 8'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    model_cmd(1'b0, 0, 1'b1, 0, 0, 0, 0);
    push_expected();
    for (int k = 0; k < 3; k++) begin
      model_sweep();
      push_expected();
    end
    e = sb_q.pop_front();
    n_checks++;
    if (dut_pal() !== e.pal || busy !== e.busy) begin
      n_fail++;
      $display("FAIL fade_down_accept: got %h busy %b expected %h busy %b", dut_pal(), busy, e.pal, e.busy);
    end
    for (int k = 0; k < 3; k++) begin
      wait_sweep();
      e = sb_q.pop_front();
      n_checks++;
      if (dut_pal() !== e.pal || busy !== e.busy) begin
        n_fail++;
        $display("FAIL fade_down_tick%0d: got %h busy %b expected %h busy %b", k, dut_pal(), busy, e.pal, e.busy);
      end
      n_checks++;
      if (red_v[7:0] !== lit[k]) begin
        n_fail++;
        $display("FAIL fade_down_red%0d: got %h expected %h", k, red_v[7:0], lit[k]);
      end
    end
  endtask

  task automatic test_out_of_range();
    snap_t e;
    send_cmd(1'b0, 8'd7, 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'h00);
    model_cmd(1'b0, 7, 1'b0, 'hAA, 'hBB, 'hCC, 0);
    push_expected();
    e = sb_q.pop_front();
    n_checks++;
    if (dut_pal() !== e.pal || busy !== e.busy) begin
      n_fail++;
      $display("FAIL oor_color: got %h busy %b expected %h busy %b", dut_pal(), busy, e.pal, e.busy);
    end
    send_cmd(1'b1, 8'd4, 1'b1, 8'h00, 8'h00, 8'h00, 8'h77);
    model_cmd(1'b1, 4, 1'b1, 0, 0, 0, 'h77);
    push_expected();
    e = sb_q.pop_front();
    n_checks++;
    if (dut_pal() !== e.pal || busy !== e.busy) begin
      n_fail++;
      $display("FAIL oor_basic_fade: got %h busy %b expected %h busy %b", dut_pal(), busy, e.pal, e.busy);
    end
  endtask

  task automatic test_back_to_back();
    snap_t e;
    int    w = 0;
    int    blocked = 0;
    while (cmd_ready && w < 1100) begin
      step_clk();
      w++;
    end
    cmd_is_basic = 1'b1;
    cmd_index    = 8'd3;
    cmd_fade     = 1'b0;
    cmd_lumin    = 8'h33;
    cmd_valid    = 1'b1;
    while (!cmd_ready && blocked < 100) begin
      blocked++;
      step_clk();
    end
    n_checks++;
    if (blocked != C) begin n_fail++; $display("FAIL ready_low_cycles: got %0d expected %0d", blocked, C); end
    step_clk();
    cmd_valid = 1'b0;
    model_sweep();
    model_cmd(1'b1, 3, 1'b0, 0, 0, 0, 'h33);
    push_expected();
    e = sb_q.pop_front();
    n_checks++;
    if (dut_pal() !== e.pal || busy !== e.busy) begin
      n_fail++;
      $display("FAIL held_cmd_accept: got %h busy %b expected %h busy %b", dut_pal(), busy, e.pal, e.busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    snap_t e;
    int    w = 0;
    send_cmd(1'b0, 8'd3, 1'b1, 8'h80, 8'h40, 8'h20, 8'h00);
    model_cmd(1'b0, 3, 1'b1, 'h80, 'h40, 'h20, 0);
    push_expected();
    e = sb_q.pop_front();
    n_checks++;
    if (dut_pal() !== e.pal || busy !== e.busy) begin
      n_fail++;
      $display("FAIL mid_fade_accept: got %h busy %b expected %h busy %b", dut_pal(), busy, e.pal, e.busy);
    end
    while (cmd_ready && w < 1100) begin
      step_clk();
      w++;
    end
    repeat (5) step_clk();
    n_checks++;
    if (red_v[31:24] !== 8'h10 || grn_v[31:24] !== 8'h00) begin
      n_fail++;
      $display("FAIL partial_sweep: got red %h green %h expected 10/00", red_v[31:24], grn_v[31:24]);
    end
    arst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_pal() !== '0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got %h busy %b ready %b expected 0/0/0", dut_pal(), busy, cmd_ready);
    end
    step_clk();
    arst_n = 1'b1;
    step_clk();
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", cmd_ready); end
    model_reset();
    wait_sweep();
    model_sweep();
    push_expected();
    e = sb_q.pop_front();
    n_checks++;
    if (dut_pal() !== e.pal || busy !== e.busy) begin
      n_fail++;
      $display("FAIL post_reset_tick: got %h busy %b expected %h busy %b", dut_pal(), busy, e.pal, e.busy);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_immediate();
    test_fade_up();
    test_fade_down();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
